step_control_unit: RTL and testbench
====================================

Name: step_control_unit

Overview:
- Control section of the 7-step processor: a step counter (steps 1–7) plus an instruction decoder.
- Drives the bus-enable and register-set strobes that sequence the datapath: IAR, MAR, RAM, IR, TMP, ACC, ALU, flags and R0–R3.
- Runs fetch in steps 1–3 and execute in steps 4–6; step 7 is idle and rolls the counter back to step 1.

Parameters:
- NUM_STEPS, 7, steps per instruction; the counter wraps after the last step.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ir  input  8  current instruction from the instruction register; valid from step 3.
- flags  input  4  latched ALU flags {C, A_larger, Eq, Z}.
- step  output  3  current step, 0..6 encoding steps 1..7.
- bus1  output  1  forces 0x01 onto the ALU B input.
- en_iar, en_ram, en_acc  output  1 each  bus enables.
- en_reg  output  4  one-hot enable for R0..R3 onto the bus.
- set_iar, set_mar, set_ram, set_ir, set_tmp, set_acc, set_flags  output  1 each  register set strobes.
- set_reg  output  4  one-hot set for R0..R3.
- alu_op  output  3  ALU operation code.
- instr_done  output  1  high during step 7.

Behaviour:
- Step counter:
  - Async reset to 0.
  - Increments on each rising clk edge.
  - 6 -> 0 wrap.
- Strobe timing:
  - All strobes are combinational from (step, ir, flags).
  - Each strobe is held for the whole step; the target register captures on the clk edge that ends the step.
  - While reset is high, every strobe, alu_op and instr_done is forced to 0.
- Default per step: all strobes 0, alu_op = 000 (ADD).
- Bus rule: at most one of en_iar, en_ram, en_acc, en_reg[*] is high in any step.
- RA = ir[3:2], RB = ir[1:0].
- Fetch:
  - s1: bus1, en_iar, set_mar, set_acc, alu_op = ADD.
  - s2: en_ram, set_ir.
  - s3: en_acc, set_iar.
- Execute, ALU (ir[7]=1):
  - s4: en_reg[RB], set_tmp.
  - s5: en_reg[RA], alu_op = ir[6:4], set_acc, set_flags.
  - s6: en_acc, set_reg[RB]; suppressed when ir[6:4] = 111 (CMP).
- Execute, LD (0000): s4 en_reg[RA], set_mar; s5 en_ram, set_reg[RB].
- Execute, ST (0001): s4 en_reg[RA], set_mar; s5 en_reg[RB], set_ram.
- Execute, DATA (0010): s4 bus1, en_iar, set_mar, set_acc; s5 en_ram, set_reg[RB]; s6 en_acc, set_iar.
- Execute, JMPR (0011): s4 en_reg[RB], set_iar.
- Execute, JMP (0100): s4 en_iar, set_mar; s5 en_ram, set_iar.
- Execute, JCAEZ (0101):
  - s4: bus1, en_iar, set_mar, set_acc.
  - s5: en_acc, set_iar.
  - s6: en_ram, set_iar, only if (ir[3:0] & flags) != 0.
- Execute, CLF (0110): s4 bus1, alu_op = ADD, set_flags.
- Execute, 0111 (IO): treated as NOP; no strobes in s4–s6.
- Unused execute steps and s7 assert nothing; instr_done = 1 in s7 only.
- Flags sampled combinationally in s6; a flags change mid-instruction is only seen if it is present during s6.
- Reset mid-instruction:
  - Strobes drop immediately.
  - On release, the counter restarts at step 1; the partial instruction is abandoned.

Optional Feature:
- Macro: STEP_CONTROL_SINGLE_STEP_EN.
- When defined:
  - Adds input go (1 bit).
  - The counter holds in step 7 (instr_done = 1) until go is sampled high at a clk edge, then advances to step 1.
  - go held high runs continuously.
  - go is ignored in steps 1–6.
- When undefined:
  - No go port.
  - Free-running wrap.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants (OP_LD, OP_ST, OP_DATA, OP_JMPR, OP_JMP, OP_JCAEZ, OP_CLF, OP_IO);
  - ALU codes (ADD=000, SHR, SHL, NOT, AND, OR, XOR, CMP=111);
  - step encodings STEP1..STEP7;
  - flag bit indices.
- One sub-module: step_counter, holding the counter, wrap logic and the single-step hold.
- The decoder stays in the top level.

Test Plan:
- Reset asserted mid-s4, released -> all strobes 0 during reset; step = 0 on the first clk after release; s1 asserts bus1, en_iar, set_mar, set_acc.
- ir = 0x86 (ADD R1,R2):
  - s4: en_reg = 0100, set_tmp.
  - s5: en_reg = 0010, alu_op = 000, set_acc, set_flags.
  - s6: en_acc, set_reg = 0100.
  - ir = 0xF6 (CMP): s6 strobes all 0.
- ir = 0x1B (ST R2,R3): s4 en_reg = 0100, set_mar; s5 en_reg = 1000, set_ram; s6 all 0.
- ir = 0x58 (JC): flags = 1000 -> s6 en_ram, set_iar; flags = 0111 -> s6 all 0.
- ir = 0x22 (DATA R2): s4 bus1, en_iar, set_mar, set_acc; s5 en_ram, set_reg = 0100; s6 en_acc, set_iar.
- Every cycle of all runs: bus-enable one-hot-or-zero check passes. Free run: instr_done pulses every 7 clocks. With STEP_CONTROL_SINGLE_STEP_EN and go = 0: step stays 6. A one-cycle go pulse advances exactly one instruction.

Source files
------------

// File: rtl/step_control_unit_pkg.sv
// Shared constants for the 7-step processor control unit: opcodes, ALU codes,
// step encodings, flag bit positions and the packed strobe bundle.
package cpu_ctrl_pkg;

    localparam int NUM_STEPS_DEFAULT = 7;

    typedef enum logic [2:0] {
        STEP1 = 3'd0,
        STEP2 = 3'd1,
        STEP3 = 3'd2,
        STEP4 = 3'd3,
        STEP5 = 3'd4,
        STEP6 = 3'd5,
        STEP7 = 3'd6
    } step_e;

    // Upper nibble of a non-ALU instruction (ir[7] = 0).
    localparam logic [3:0] OP_LD    = 4'b0000;
    localparam logic [3:0] OP_ST    = 4'b0001;
    localparam logic [3:0] OP_DATA  = 4'b0010;
    localparam logic [3:0] OP_JMPR  = 4'b0011;
    localparam logic [3:0] OP_JMP   = 4'b0100;
    localparam logic [3:0] OP_JCAEZ = 4'b0101;
    localparam logic [3:0] OP_CLF   = 4'b0110;
    localparam logic [3:0] OP_IO    = 4'b0111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SHR = 3'b001,
        ALU_SHL = 3'b010,
        ALU_NOT = 3'b011,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101,
        ALU_XOR = 3'b110,
        ALU_CMP = 3'b111
    } alu_op_e;

    localparam int FLAG_Z       = 0;
    localparam int FLAG_EQ      = 1;
    localparam int FLAG_ALARGER = 2;
    localparam int FLAG_C       = 3;

    typedef struct packed {
        logic       bus1;
        logic       en_iar;
        logic       en_ram;
        logic       en_acc;
        logic [3:0] en_reg;
        logic       set_iar;
        logic       set_mar;
        logic       set_ram;
        logic       set_ir;
        logic       set_tmp;
        logic       set_acc;
        logic       set_flags;
        logic [3:0] set_reg;
        alu_op_e    alu_op;
        logic       instr_done;
    } ctrl_t;

    function automatic logic [3:0] reg_sel(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/step_control_unit_if.sv
// Control-unit <-> datapath signal bundle. Optional go input exists only
// when STEP_CONTROL_SINGLE_STEP_EN is defined.
interface step_control_unit_if;
    logic [7:0] ir;
    logic [3:0] flags;
`ifdef STEP_CONTROL_SINGLE_STEP_EN
    logic       go;
`endif
    logic [2:0] step;
    logic       bus1;
    logic       en_iar;
    logic       en_ram;
    logic       en_acc;
    logic [3:0] en_reg;
    logic       set_iar;
    logic       set_mar;
    logic       set_ram;
    logic       set_ir;
    logic       set_tmp;
    logic       set_acc;
    logic       set_flags;
    logic [3:0] set_reg;
    logic [2:0] alu_op;
    logic       instr_done;

    // master = control unit (drives strobes), slave = datapath.
`ifdef STEP_CONTROL_SINGLE_STEP_EN
    modport master (
        input  ir, flags, go,
        output step, bus1, en_iar, en_ram, en_acc, en_reg,
               set_iar, set_mar, set_ram, set_ir, set_tmp, set_acc, set_flags,
               set_reg, alu_op, instr_done
    );
    modport slave (
        output ir, flags, go,
        input  step, bus1, en_iar, en_ram, en_acc, en_reg,
               set_iar, set_mar, set_ram, set_ir, set_tmp, set_acc, set_flags,
               set_reg, alu_op, instr_done
    );
`else
    modport master (
        input  ir, flags,
        output step, bus1, en_iar, en_ram, en_acc, en_reg,
               set_iar, set_mar, set_ram, set_ir, set_tmp, set_acc, set_flags,
               set_reg, alu_op, instr_done
    );
    modport slave (
        output ir, flags,
        input  step, bus1, en_iar, en_ram, en_acc, en_reg,
               set_iar, set_mar, set_ram, set_ir, set_tmp, set_acc, set_flags,
               set_reg, alu_op, instr_done
    );
`endif
endinterface

// File: rtl/step_control_unit_counter.sv
// Step counter 0..NUM_STEPS-1 with wrap; when STEP_CONTROL_SINGLE_STEP_EN is
// defined it parks on the last step until go is sampled high.
module step_counter
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_STEPS = NUM_STEPS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
`ifdef STEP_CONTROL_SINGLE_STEP_EN
    input  logic       go_i,
`endif
    output logic [2:0] step_o
);

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    logic [2:0] step_q;
    logic [2:0] step_d;

    always_comb begin
        step_d = step_q + 3'd1;
        if (step_q == LAST_STEP) begin
`ifdef STEP_CONTROL_SINGLE_STEP_EN
            step_d = go_i ? 3'd0 : step_q;
`else
            step_d = 3'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= 3'd0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/step_control_unit.sv
// Control section of the 7-step processor: step counter plus instruction
// decoder. Optional single-step hold via STEP_CONTROL_SINGLE_STEP_EN.
module step_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_STEPS = NUM_STEPS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    step_control_unit_if.master bus
);

    logic [2:0] step_w;
    ctrl_t      ctl;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [2:0] alu_fn;
    logic       jump_taken;

    step_counter #(
        .NUM_STEPS (NUM_STEPS)
    ) u_step_counter (
        .clk    (clk),
        .reset  (reset),
`ifdef STEP_CONTROL_SINGLE_STEP_EN
        .go_i   (bus.go),
`endif
        .step_o (step_w)
    );

    assign ra         = bus.ir[3:2];
    assign rb         = bus.ir[1:0];
    assign alu_fn     = bus.ir[6:4];
    assign jump_taken = |(bus.ir[3:0] & bus.flags);

    always_comb begin
        ctl = '0;
        unique case (step_e'(step_w))
            STEP1: begin
                ctl.bus1    = 1'b1;
                ctl.en_iar  = 1'b1;
                ctl.set_mar = 1'b1;
                ctl.set_acc = 1'b1;
                ctl.alu_op  = ALU_ADD;
            end
            STEP2: begin
                ctl.en_ram = 1'b1;
                ctl.set_ir = 1'b1;
            end
            STEP3: begin
                ctl.en_acc  = 1'b1;
                ctl.set_iar = 1'b1;
            end
            STEP4: begin
                if (bus.ir[7]) begin
                    ctl.en_reg  = reg_sel(rb);
                    ctl.set_tmp = 1'b1;
                end else begin
                    case (bus.ir[7:4])
                        OP_LD, OP_ST: begin
                            ctl.en_reg  = reg_sel(ra);
                            ctl.set_mar = 1'b1;
                        end
                        OP_DATA, OP_JCAEZ: begin
                            ctl.bus1    = 1'b1;
                            ctl.en_iar  = 1'b1;
                            ctl.set_mar = 1'b1;
                            ctl.set_acc = 1'b1;
                        end
                        OP_JMPR: begin
                            ctl.en_reg  = reg_sel(rb);
                            ctl.set_iar = 1'b1;
                        end
                        OP_JMP: begin
                            ctl.en_iar  = 1'b1;
                            ctl.set_mar = 1'b1;
                        end
                        OP_CLF: begin
                            ctl.bus1      = 1'b1;
                            ctl.alu_op    = ALU_ADD;
                            ctl.set_flags = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            STEP5: begin
                if (bus.ir[7]) begin
                    ctl.en_reg    = reg_sel(ra);
                    ctl.alu_op    = alu_op_e'(alu_fn);
                    ctl.set_acc   = 1'b1;
                    ctl.set_flags = 1'b1;
                end else begin
                    case (bus.ir[7:4])
                        OP_LD, OP_DATA: begin
                            ctl.en_ram  = 1'b1;
                            ctl.set_reg = reg_sel(rb);
                        end
                        OP_ST: begin
                            ctl.en_reg  = reg_sel(rb);
                            ctl.set_ram = 1'b1;
                        end
                        OP_JMP: begin
                            ctl.en_ram  = 1'b1;
                            ctl.set_iar = 1'b1;
                        end
                        OP_JCAEZ: begin
                            ctl.en_acc  = 1'b1;
                            ctl.set_iar = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            STEP6: begin
                // CMP only updates flags, so its write-back is suppressed.
                if (bus.ir[7]) begin
                    if (alu_fn != ALU_CMP) begin
                        ctl.en_acc  = 1'b1;
                        ctl.set_reg = reg_sel(rb);
                    end
                end else begin
                    case (bus.ir[7:4])
                        OP_DATA: begin
                            ctl.en_acc  = 1'b1;
                            ctl.set_iar = 1'b1;
                        end
                        OP_JCAEZ: begin
                            if (jump_taken) begin
                                ctl.en_ram  = 1'b1;
                                ctl.set_iar = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            STEP7: begin
                ctl.instr_done = 1'b1;
            end
            default: ;
        endcase

        // Strobes must drop immediately on reset, not only after the counter clears.
        if (reset) begin
            ctl = '0;
        end
    end

    assign bus.step       = step_w;
    assign bus.bus1       = ctl.bus1;
    assign bus.en_iar     = ctl.en_iar;
    assign bus.en_ram     = ctl.en_ram;
    assign bus.en_acc     = ctl.en_acc;
    assign bus.en_reg     = ctl.en_reg;
    assign bus.set_iar    = ctl.set_iar;
    assign bus.set_mar    = ctl.set_mar;
    assign bus.set_ram    = ctl.set_ram;
    assign bus.set_ir     = ctl.set_ir;
    assign bus.set_tmp    = ctl.set_tmp;
    assign bus.set_acc    = ctl.set_acc;
    assign bus.set_flags  = ctl.set_flags;
    assign bus.set_reg    = ctl.set_reg;
    assign bus.alu_op     = ctl.alu_op;
    assign bus.instr_done = ctl.instr_done;

endmodule

// File: tb/tb_step_control_unit.sv
// Directed table-driven bench for step_control_unit, plus reset, period and
// (with STEP_CONTROL_SINGLE_STEP_EN) single-step sequences.
module tb_step_control_unit;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    step_control_unit_if ctrl_if ();

    step_control_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ctrl_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ir;
        logic [3:0]  fl;
        logic [2:0]  stp;
        logic [22:0] exp;
        string       nm;
    } vec_t;

    vec_t vq[$];

    // {bus1,en_iar,en_ram,en_acc}, en_reg, {set_iar,mar,ram,ir,tmp,acc,flags}, set_reg, alu_op, done
    function automatic logic [22:0] mk(input logic [3:0] en, input logic [3:0] ereg,
                                       input logic [6:0] sets, input logic [3:0] sreg,
                                       input logic [2:0] op, input logic done);
        return {en, ereg, sets, sreg, op, done};
    endfunction

    function automatic logic [22:0] act();
        return {ctrl_if.bus1, ctrl_if.en_iar, ctrl_if.en_ram, ctrl_if.en_acc, ctrl_if.en_reg,
                ctrl_if.set_iar, ctrl_if.set_mar, ctrl_if.set_ram, ctrl_if.set_ir,
                ctrl_if.set_tmp, ctrl_if.set_acc, ctrl_if.set_flags, ctrl_if.set_reg,
                ctrl_if.alu_op, ctrl_if.instr_done};
    endfunction

    task automatic add(input logic [7:0] ir, input logic [3:0] fl, input logic [2:0] stp,
                       input logic [22:0] exp, input string nm);
        vec_t v;
        v.ir = ir; v.fl = fl; v.stp = stp; v.exp = exp; v.nm = nm;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Advance to the next falling edge and check the bus-enable rule there.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            checks++;
            if ($countones({ctrl_if.en_iar, ctrl_if.en_ram, ctrl_if.en_acc, ctrl_if.en_reg}) > 1) begin
                failures++;
                $display("FAIL bus_onehot: step=%0d en={%b%b%b,%b} expected at most one",
                         ctrl_if.step, ctrl_if.en_iar, ctrl_if.en_ram, ctrl_if.en_acc, ctrl_if.en_reg);
            end
        end
    endtask

    task automatic wait_step(input logic [2:0] s, input string nm);
        for (int i = 0; i < 20; i++) begin
            if (ctrl_if.step == s) return;
            tick();
        end
        failures++;
        $display("FAIL %s: step %0d not reached, got=%0d", nm, s, ctrl_if.step);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        ctrl_if.ir    = 8'h00;
        ctrl_if.flags = 4'h0;
`ifdef STEP_CONTROL_SINGLE_STEP_EN
        ctrl_if.go    = 1'b1;
`endif

        add(8'h86, 4'h0, 3'd0, mk(4'b1100, 4'b0000, 7'b0100010, 4'b0000, 3'b000, 1'b0), "fetch_s1");
        add(8'h86, 4'h0, 3'd1, mk(4'b0010, 4'b0000, 7'b0001000, 4'b0000, 3'b000, 1'b0), "fetch_s2");
        add(8'h86, 4'h0, 3'd2, mk(4'b0001, 4'b0000, 7'b1000000, 4'b0000, 3'b000, 1'b0), "fetch_s3");
        add(8'h86, 4'h0, 3'd3, mk(4'b0000, 4'b0100, 7'b0000100, 4'b0000, 3'b000, 1'b0), "add_s4");
        add(8'h86, 4'h0, 3'd4, mk(4'b0000, 4'b0010, 7'b0000011, 4'b0000, 3'b000, 1'b0), "add_s5");
        add(8'h86, 4'h0, 3'd5, mk(4'b0001, 4'b0000, 7'b0000000, 4'b0100, 3'b000, 1'b0), "add_s6");
        add(8'h86, 4'h0, 3'd6, mk(4'b0000, 4'b0000, 7'b0000000, 4'b0000, 3'b000, 1'b1), "add_s7");
        add(8'hF6, 4'h0, 3'd4, mk(4'b0000, 4'b0010, 7'b0000011, 4'b0000, 3'b111, 1'b0), "cmp_s5");
        add(8'hF6, 4'h0, 3'd5, '0, "cmp_s6");
        add(8'h1B, 4'h0, 3'd3, mk(4'b0000, 4'b0100, 7'b0100000, 4'b0000, 3'b000, 1'b0), "st_s4");
        add(8'h1B, 4'h0, 3'd4, mk(4'b0000, 4'b1000, 7'b0010000, 4'b0000, 3'b000, 1'b0), "st_s5");
        add(8'h1B, 4'h0, 3'd5, '0, "st_s6");
        add(8'h58, 4'h8, 3'd3, mk(4'b1100, 4'b0000, 7'b0100010, 4'b0000, 3'b000, 1'b0), "jc_s4");
        add(8'h58, 4'h8, 3'd4, mk(4'b0001, 4'b0000, 7'b1000000, 4'b0000, 3'b000, 1'b0), "jc_s5");
        add(8'h58, 4'h8, 3'd5, mk(4'b0010, 4'b0000, 7'b1000000, 4'b0000, 3'b000, 1'b0), "jc_taken_s6");
        add(8'h58, 4'h7, 3'd5, '0, "jc_nottaken_s6");
        add(8'h22, 4'h0, 3'd3, mk(4'b1100, 4'b0000, 7'b0100010, 4'b0000, 3'b000, 1'b0), "data_s4");
        add(8'h22, 4'h0, 3'd4, mk(4'b0010, 4'b0000, 7'b0000000, 4'b0100, 3'b000, 1'b0), "data_s5");
        add(8'h22, 4'h0, 3'd5, mk(4'b0001, 4'b0000, 7'b1000000, 4'b0000, 3'b000, 1'b0), "data_s6");
        add(8'h0E, 4'h0, 3'd3, mk(4'b0000, 4'b1000, 7'b0100000, 4'b0000, 3'b000, 1'b0), "ld_s4");
        add(8'h0E, 4'h0, 3'd4, mk(4'b0010, 4'b0000, 7'b0000000, 4'b0100, 3'b000, 1'b0), "ld_s5");
        add(8'h31, 4'h0, 3'd3, mk(4'b0000, 4'b0010, 7'b1000000, 4'b0000, 3'b000, 1'b0), "jmpr_s4");
        add(8'h31, 4'h0, 3'd4, '0, "jmpr_s5");
        add(8'h40, 4'h0, 3'd3, mk(4'b0100, 4'b0000, 7'b0100000, 4'b0000, 3'b000, 1'b0), "jmp_s4");
        add(8'h40, 4'h0, 3'd4, mk(4'b0010, 4'b0000, 7'b1000000, 4'b0000, 3'b000, 1'b0), "jmp_s5");
        add(8'h60, 4'h0, 3'd3, mk(4'b1000, 4'b0000, 7'b0000001, 4'b0000, 3'b000, 1'b0), "clf_s4");
        add(8'h70, 4'h0, 3'd3, '0, "io_s4");
        add(8'h70, 4'h0, 3'd4, '0, "io_s5");
        add(8'h70, 4'h0, 3'd5, '0, "io_s6");
        add(8'hA6, 4'h0, 3'd4, mk(4'b0000, 4'b0010, 7'b0000011, 4'b0000, 3'b010, 1'b0), "shl_s5");
        add(8'hA6, 4'h0, 3'd5, mk(4'b0001, 4'b0000, 7'b0000000, 4'b0100, 3'b000, 1'b0), "shl_s6");

        // Reset state
        #2;
        check("reset_strobes", 32'(act()), 32'd0);
        check("reset_step", 32'(ctrl_if.step), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        check("release_step", 32'(ctrl_if.step), 32'd0);

        foreach (vq[i]) begin
            ctrl_if.ir    = vq[i].ir;
            ctrl_if.flags = vq[i].fl;
            wait_step(vq[i].stp, vq[i].nm);
            #1;
            check(vq[i].nm, 32'(act()), 32'(vq[i].exp));
        end

        // Reset asserted mid-s4
        ctrl_if.ir    = 8'h86;
        ctrl_if.flags = 4'h0;
        wait_step(3'd3, "rst_mid_wait");
        reset = 1'b1;
        #1;
        check("rst_mid_strobes", 32'(act()), 32'd0);
        check("rst_mid_step", 32'(ctrl_if.step), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_strobes", 32'(act()), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        check("rst_rel_step", 32'(ctrl_if.step), 32'd0);
        check("rst_rel_s1", 32'(act()), 32'(mk(4'b1100, 4'b0000, 7'b0100010, 4'b0000, 3'b000, 1'b0)));
        tick();
        check("rst_rel_next_step", 32'(ctrl_if.step), 32'd1);

        // instr_done period
        wait_step(3'd6, "period_wait");
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!ctrl_if.instr_done && n < 20);
            check("done_period", 32'(n), 32'd7);
        end

`ifdef STEP_CONTROL_SINGLE_STEP_EN
        ctrl_if.go = 1'b0;
        wait_step(3'd6, "ss_wait");
        for (int k = 0; k < 5; k++) tick();
        check("ss_hold_step", 32'(ctrl_if.step), 32'd6);
        check("ss_hold_done", 32'(ctrl_if.instr_done), 32'd1);
        ctrl_if.go = 1'b1;
        @(posedge clk);
        #1 ctrl_if.go = 1'b0;
        tick();
        check("ss_pulse_step", 32'(ctrl_if.step), 32'd0);
        for (int k = 0; k < 6; k++) tick();
        check("ss_one_instr", 32'(ctrl_if.step), 32'd6);
        for (int k = 0; k < 3; k++) tick();
        check("ss_rehold", 32'(ctrl_if.step), 32'd6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
